caf_search_ctrl: RTL

- Sequences a cross-ambiguity search over a bank of frequency bins, driving one arg_max-style magnitude/argmax engine per bin.
- Per bin, the block:
  - programs the frequency-shift index;
  - gates exactly `buffer_length` samples from the upstream correlator into the engine;
  - collects the engine's (max, index) result.
- Across all bins it keeps the global peak and reports (best_max, best_index, best_freq) once per search.
- Sits between the correlator/frequency-shifter front end and the engine's result interface.

---
 rtl/caf_pkg.sv | 29 ++
 rtl/caf_stream_gate.sv | 47 ++++
 rtl/caf_search_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/caf_pkg.sv
// ============================================================================
//  caf_pkg : shared state encoding and default widths for the CAF search block
//  Revision: 1.0
// ============================================================================
`default_nettype none

package caf_pkg;

   localparam int unsigned CAF_INDEX_BITS   = 4;
   localparam int unsigned CAF_OUT_MAX_BITS = 4;
   localparam int unsigned CAF_FREQ_BITS    = 3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETTLE   = 3'd1,
      ST_STREAM   = 3'd2,
      ST_WAIT_RES = 3'd3,
      ST_UPDATE   = 3'd4,
      ST_DONE     = 3'd5
   } caf_state_e;

   // Bits needed to hold every value 0..max_val inclusive (never less than 1).
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/caf_stream_gate.sv
// ============================================================================
//  caf_stream_gate : gates upstream samples into the engine and counts beats
//  Revision: 1.0
// ============================================================================
`default_nettype none

module caf_stream_gate
   import caf_pkg::*;
#(
   parameter int unsigned BUFFER_LENGTH = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_gate,
   input  logic i_src_tvalid,
   input  logic i_eng_tready,
   output logic o_src_tready,
   output logic o_eng_tvalid,
   output logic o_last_beat
);

   localparam int unsigned          c_cnt_w = cnt_width(BUFFER_LENGTH);
   localparam logic [c_cnt_w-1:0]   c_last  = c_cnt_w'(BUFFER_LENGTH - 1);

   logic [c_cnt_w-1:0] r_count;
   logic               w_xfer;

   assign o_src_tready = i_eng_tready & i_gate;
   assign o_eng_tvalid = i_src_tvalid & i_gate;
   assign w_xfer       = i_src_tvalid & i_eng_tready & i_gate;
   assign o_last_beat  = w_xfer && (r_count == c_last);

   // Stalls on either side of the handshake simply hold the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (w_xfer) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/caf_search_ctrl.sv
// ============================================================================
//  caf_search_ctrl : sequences a per-bin arg-max search and tracks the global peak
//  Revision: 1.0
// ============================================================================
`default_nettype none

module caf_search_ctrl
   import caf_pkg::*;
#(
   parameter int unsigned BUFFER_LENGTH = 10,
   parameter int unsigned INDEX_BITS    = CAF_INDEX_BITS,
   parameter int unsigned FREQ_BITS     = CAF_FREQ_BITS,
   parameter int unsigned NUM_FREQ_BINS = 8,
   parameter int unsigned OUT_MAX_BITS  = CAF_OUT_MAX_BITS,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic [FREQ_BITS-1:0]    freq_idx,
   input  logic                    src_tvalid,
   output logic                    src_tready,
   output logic                    eng_tvalid,
   input  logic                    eng_tready,
   input  logic                    res_tvalid,
   input  logic [OUT_MAX_BITS-1:0] res_max,
   input  logic [INDEX_BITS-1:0]   res_index,
   output logic                    res_tready,
   output logic [OUT_MAX_BITS-1:0] best_max,
   output logic [INDEX_BITS-1:0]   best_index,
   output logic [FREQ_BITS-1:0]    best_freq
);

   // A zero settle still spends one cycle in SETTLE, so both map to a terminal count of 0.
   localparam int unsigned            c_settle_last = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
   localparam int unsigned            c_settle_w    = cnt_width(c_settle_last);
   localparam logic [c_settle_w-1:0]  c_settle_end  = c_settle_w'(c_settle_last);
   localparam logic [FREQ_BITS-1:0]   c_last_bin    = FREQ_BITS'(NUM_FREQ_BINS - 1);

   caf_state_e               r_state;
   caf_state_e               w_next;

   logic [FREQ_BITS-1:0]     r_freq_idx;
   logic [OUT_MAX_BITS-1:0]  r_best_max;
   logic [INDEX_BITS-1:0]    r_best_index;
   logic [FREQ_BITS-1:0]     r_best_freq;
   logic [OUT_MAX_BITS-1:0]  r_res_max;
   logic [INDEX_BITS-1:0]    r_res_index;
   logic [c_settle_w-1:0]    r_settle_cnt;

   logic                     w_gate;
   logic                     w_last_beat;
   logic                     w_clear;
   logic                     w_start_acc;
   logic                     w_res_hs;
   logic                     w_settle_done;
   logic                     w_last_bin;
   logic                     w_better;

   assign w_start_acc   = (r_state == ST_IDLE) && start;
   assign w_res_hs      = res_tvalid & res_tready;
   assign w_settle_done = (r_settle_cnt == c_settle_end);
   assign w_last_bin    = (r_freq_idx == c_last_bin);
   assign w_clear       = w_start_acc || (r_state == ST_UPDATE);
   // Bin 0 always seeds the peak; later bins must beat it strictly, so ties keep the earlier bin.
   assign w_better      = (r_res_max > r_best_max) || (r_freq_idx == '0);

   caf_stream_gate #(
      .BUFFER_LENGTH (BUFFER_LENGTH)
   ) u_gate (
      .clk          (clk),
      .rst          (rst),
      .i_clear      (w_clear),
      .i_gate       (w_gate),
      .i_src_tvalid (src_tvalid),
      .i_eng_tready (eng_tready),
      .o_src_tready (src_tready),
      .o_eng_tvalid (eng_tvalid),
      .o_last_beat  (w_last_beat)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:     if (start)         w_next = ST_SETTLE;
         ST_SETTLE:   if (w_settle_done) w_next = ST_STREAM;
         ST_STREAM:   if (w_last_beat)   w_next = ST_WAIT_RES;
         ST_WAIT_RES: if (w_res_hs)      w_next = ST_UPDATE;
         ST_UPDATE:   w_next = w_last_bin ? ST_DONE : ST_SETTLE;
         ST_DONE:     w_next = ST_IDLE;
         default:     w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = 1'b1;
      done       = 1'b0;
      w_gate     = 1'b0;
      res_tready = 1'b0;
      unique case (r_state)
         ST_IDLE:     busy       = 1'b0;
         ST_STREAM:   w_gate     = 1'b1;
         ST_WAIT_RES: res_tready = 1'b1;
         ST_DONE:     done       = 1'b1;
         default:     ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_settle_cnt <= '0;
      end else if (r_state == ST_SETTLE) begin
         r_settle_cnt <= r_settle_cnt + 1'b1;
      end else begin
         r_settle_cnt <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_freq_idx   <= '0;
         r_best_max   <= '0;
         r_best_index <= '0;
         r_best_freq  <= '0;
         r_res_max    <= '0;
         r_res_index  <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_freq_idx   <= '0;
                  r_best_max   <= '0;
                  r_best_index <= '0;
                  r_best_freq  <= '0;
               end
            end
            ST_WAIT_RES: begin
               if (w_res_hs) begin
                  r_res_max   <= res_max;
                  r_res_index <= res_index;
               end
            end
            ST_UPDATE: begin
               if (w_better) begin
                  r_best_max   <= r_res_max;
                  r_best_index <= r_res_index;
                  r_best_freq  <= r_freq_idx;
               end
               if (!w_last_bin) begin
                  r_freq_idx <= r_freq_idx + 1'b1;
               end
            end
            ST_DONE: begin
               r_freq_idx <= '0;
            end
            default: ;
         endcase
      end
   end

   assign freq_idx   = r_freq_idx;
   assign best_max   = r_best_max;
   assign best_index = r_best_index;
   assign best_freq  = r_best_freq;

endmodule

`default_nettype wire
